// File: rtl/get_num.sv
// rtl/get_num.sv - Huffman front-end digit frequency counter (ten per-digit occurrence counters)
// Optional build macro: GET_NUM_SATURATE_EN (counters saturate instead of wrapping).
module get_num #(
    parameter int                DATA_W   = 4,
    parameter int                CNT_W    = 8,
    parameter logic [DATA_W-1:0] END_CODE = 4'hF
) (
    input  logic              Clk_in,
    input  logic              nRst,
    input  logic              Start,
    input  logic [DATA_W-1:0] Data_in,
    output logic [CNT_W-1:0]  Num0,
    output logic [CNT_W-1:0]  Num1,
    output logic [CNT_W-1:0]  Num2,
    output logic [CNT_W-1:0]  Num3,
    output logic [CNT_W-1:0]  Num4,
    output logic [CNT_W-1:0]  Num5,
    output logic [CNT_W-1:0]  Num6,
    output logic [CNT_W-1:0]  Num7,
    output logic [CNT_W-1:0]  Num8,
    output logic [CNT_W-1:0]  Num9
);

    localparam int NUM_SYM = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state;
    state_t next_state;

    logic clr_all;
    logic cnt_en;

    logic [CNT_W-1:0]   cnt     [NUM_SYM];
    logic [NUM_SYM-1:0] hit;
    logic [NUM_SYM-1:0] blocked;

    always_ff @(posedge Clk_in or negedge nRst) begin
        if (!nRst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The edge on which Start is first seen low in ARM is already a counting edge.
    always_comb begin
        next_state = state;
        clr_all    = 1'b0;
        cnt_en     = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    clr_all    = 1'b1;
                    next_state = ARM;
                end
            end
            ARM, COUNT: begin
                if (Start) begin
                    clr_all    = 1'b1;
                    next_state = ARM;
                end else begin
                    cnt_en     = 1'b1;
                    next_state = (Data_in == END_CODE) ? DONE : COUNT;
                end
            end
            DONE: begin
                if (Start) begin
                    clr_all    = 1'b1;
                    next_state = ARM;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // One-hot symbol decode; codes 10..END_CODE never match a counter.
    always_comb begin
        hit     = '0;
        blocked = '0;
        for (int i = 0; i < NUM_SYM; i++) begin
            hit[i] = cnt_en && (Data_in == DATA_W'(i));
`ifdef GET_NUM_SATURATE_EN
            blocked[i] = &cnt[i];
`else
            blocked[i] = 1'b0;
`endif
        end
    end

    always_ff @(posedge Clk_in or negedge nRst) begin
        if (!nRst) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                cnt[i] <= '0;
            end
        end else if (clr_all) begin
            for (int i = 0; i < NUM_SYM; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SYM; i++) begin
                if (hit[i] && !blocked[i]) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign Num0 = cnt[0];
    assign Num1 = cnt[1];
    assign Num2 = cnt[2];
    assign Num3 = cnt[3];
    assign Num4 = cnt[4];
    assign Num5 = cnt[5];
    assign Num6 = cnt[6];
    assign Num7 = cnt[7];
    assign Num8 = cnt[8];
    assign Num9 = cnt[9];

endmodule

// File: tb/tb_get_num.sv
// tb/tb_get_num.sv - randomized self-checking bench for get_num against a run/idle count model
module tb_get_num;

    logic       Clk_in = 1'b0;
    logic       nRst;
    logic       Start;
    logic [3:0] Data_in;
    logic [7:0] Num0, Num1, Num2, Num3, Num4, Num5, Num6, Num7, Num8, Num9;
    logic [7:0] num [10];

    int n_checks = 0;
    int n_fail   = 0;

    // Model: a run is either active (armed or counting) or not; counts are plain ints.
    int exp_cnt [10];
    bit running;

    always #5 Clk_in = ~Clk_in;

    get_num dut (
        .Clk_in  (Clk_in),
        .nRst    (nRst),
        .Start   (Start),
        .Data_in (Data_in),
        .Num0    (Num0),
        .Num1    (Num1),
        .Num2    (Num2),
        .Num3    (Num3),
        .Num4    (Num4),
        .Num5    (Num5),
        .Num6    (Num6),
        .Num7    (Num7),
        .Num8    (Num8),
        .Num9    (Num9)
    );

    assign num[0] = Num0;
    assign num[1] = Num1;
    assign num[2] = Num2;
    assign num[3] = Num3;
    assign num[4] = Num4;
    assign num[5] = Num5;
    assign num[6] = Num6;
    assign num[7] = Num7;
    assign num[8] = Num8;
    assign num[9] = Num9;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 10; i++) begin
            check_eq($sformatf("%s.Num%0d", tag, i), int'(num[i]), exp_cnt[i]);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 10; i++) exp_cnt[i] = 0;
        running = 1'b0;
    endfunction

    function automatic void model_edge(input bit s, input int d);
        if (s) begin
            for (int i = 0; i < 10; i++) exp_cnt[i] = 0;
            running = 1'b1;
        end else if (running) begin
            if (d <= 9) begin
`ifdef GET_NUM_SATURATE_EN
                if (exp_cnt[d] < 255) exp_cnt[d] = exp_cnt[d] + 1;
`else
                exp_cnt[d] = (exp_cnt[d] + 1) % 256;
`endif
            end else if (d == 15) begin
                running = 1'b0;
            end
        end
    endfunction

    task automatic step(input string tag, input bit s, input int d, input bit chk);
        @(negedge Clk_in);
        Start   = s;
        Data_in = 4'(d);
        @(posedge Clk_in);
        if (nRst) model_edge(s, d);
        #1;
        if (chk) check_all(tag);
    endtask

    task automatic async_reset(input string tag);
        @(negedge Clk_in);
        #2 nRst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge Clk_in);
        nRst = 1'b1;
    endtask

    int seq [$];

    initial begin
        nRst    = 1'b0;
        Start   = 1'b0;
        Data_in = 4'd0;
        model_reset();

        for (int i = 0; i < 4; i++) step("reset_hold", 1'b0, i * 5 % 16, 1'b1);
        @(negedge Clk_in);
        nRst = 1'b1;
        for (int i = 0; i < 10; i++) step("idle_ignore", 1'b0, 3, 1'b1);

        step("preload_arm", 1'b1, 0, 1'b1);
        for (int i = 0; i < 12; i++) step("preload", 1'b0, $urandom_range(0, 9), 1'b1);
        for (int i = 0; i < 20; i++) step("arm_clear", 1'b1, 0, 1'b1);

        seq = '{8, 9, 9, 7, 6, 6, 5, 5, 5, 4, 4, 4, 4, 3, 3, 3, 3, 3, 15};
        foreach (seq[i]) step("freq_run", 1'b0, seq[i], 1'b1);
        check_eq("freq.Num3", int'(Num3), 5);
        check_eq("freq.Num4", int'(Num4), 4);
        check_eq("freq.Num9", int'(Num9), 2);
        check_eq("freq.Num0", int'(Num0), 0);
        for (int i = 0; i < 5; i++) step("frozen", 1'b0, $urandom_range(0, 9), 1'b1);

        step("inv_arm", 1'b1, 0, 1'b1);
        step("inv_first", 1'b0, 2, 1'b1);
        for (int i = 10; i <= 14; i++) step("invalid", 1'b0, i, 1'b1);
        step("end_code", 1'b0, 15, 1'b1);
        for (int i = 0; i < 5; i++) step("done_ignore", 1'b0, 2, 1'b1);
        check_eq("done.Num2", int'(Num2), 1);

        step("ovf_arm", 1'b1, 2, 1'b1);
        for (int i = 0; i < 300; i++) step("overflow", 1'b0, 2, 1'b0);
        check_all("overflow");
`ifdef GET_NUM_SATURATE_EN
        check_eq("overflow.Num2_abs", int'(Num2), 255);
`else
        check_eq("overflow.Num2_abs", int'(Num2), 44);
`endif

        for (int i = 0; i < 6; i++) step("restart_pre", 1'b0, $urandom_range(0, 9), 1'b1);
        step("restart", 1'b1, 4, 1'b1);
        step("resume", 1'b0, 4, 1'b1);
        check_eq("resume.Num4", int'(Num4), 1);
        for (int i = 0; i < 4; i++) step("resume_run", 1'b0, $urandom_range(0, 9), 1'b1);
        async_reset("async_reset");
        for (int i = 0; i < 3; i++) step("post_reset_idle", 1'b0, 1, 1'b1);

        for (int i = 0; i < 600; i++) begin
            int r;
            int d;
            r = $urandom_range(0, 99);
            if (r < 3)       d = 15;
            else if (r < 10) d = $urandom_range(10, 14);
            else             d = $urandom_range(0, 9);
            if (r >= 97) async_reset("rand_reset");
            else step("random", ($urandom_range(0, 49) == 0), d, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
